// File: rtl/ram_gen_pkg.sv
// ============================================================================
// Module  : ram_gen_pkg
// Brief   : Shared constants, clear-FSM state type and lane helper for ram_sp_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_gen_pkg;

    localparam int WM_WRITE_FIRST = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_READY = 2'd2
    } clr_state_t;

    function automatic int calc_nlane(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_gen_clr.sv
// ============================================================================
// Module  : ram_gen_clr
// Brief   : Post-reset sequencer that sweeps every address once with a strobe
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_gen_clr
    import ram_gen_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we
);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLR_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy      = 1'b0;
        o_we        = 1'b0;
        o_addr      = r_cnt;
        case (r_state)
            CLR_CLEAR: begin
                o_busy    = 1'b1;
                o_we      = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                // Last address is written on this same edge.
                if (&r_cnt) begin
                    w_state_nxt = CLR_READY;
                end
            end
            CLR_READY: w_state_nxt = CLR_READY;
            CLR_IDLE:  w_state_nxt = CLR_IDLE;
            default:   w_state_nxt = CLR_READY;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ram_sp_gen.sv
// ============================================================================
// Module  : ram_sp_gen
// Brief   : Parametrised single-port RAM, lane write enables, optional DO reg
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_sp_gen
    import ram_gen_pkg::*;
#(
    parameter int                 DATA_W     = 4,
    parameter int                 ADDR_W     = 12,
    parameter int                 LANE_W     = 4,
    parameter int                 WRITE_MODE = 0,
    parameter int                 OUT_REG    = 0,
    parameter logic [DATA_W-1:0]  INIT       = '0,
    parameter logic [DATA_W-1:0]  SRVAL      = '0,
    parameter int                 CLR_EN     = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL    = '0
) (
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic                                   EN,
    input  logic                                   SSR,
    input  logic [calc_nlane(DATA_W, LANE_W)-1:0]  WE,
    input  logic [ADDR_W-1:0]                      ADDR,
    input  logic [DATA_W-1:0]                      DI,
    output logic [DATA_W-1:0]                      DO,
    output logic                                   BUSY
);

    localparam int NLANE = calc_nlane(DATA_W, LANE_W);
    localparam int DEPTH = 2 ** ADDR_W;

    if (WRITE_MODE != WM_WRITE_FIRST && WRITE_MODE != WM_READ_FIRST &&
        WRITE_MODE != WM_NO_CHANGE) begin : g_bad_write_mode
        $fatal(1, "ram_sp_gen: WRITE_MODE must be 0, 1 or 2");
    end
    if ((DATA_W % LANE_W) != 0) begin : g_bad_lane
        $fatal(1, "ram_sp_gen: DATA_W must be a multiple of LANE_W");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] r_s1;
    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    if (CLR_EN != 0) begin : g_clr
        ram_gen_clr #(
            .ADDR_W (ADDR_W)
        ) u_clr (
            .clk    (CLK),
            .rst_n  (RST_N),
            .o_busy (w_busy),
            .o_addr (w_clr_addr),
            .o_we   (w_clr_we)
        );
    end else begin : g_no_clr
        assign w_busy     = 1'b0;
        assign w_clr_we   = 1'b0;
        assign w_clr_addr = '0;
    end

    assign BUSY = w_busy;
    assign w_rd = mem[ADDR];

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        assign w_merged[k*LANE_W +: LANE_W] = WE[k] ? DI[k*LANE_W +: LANE_W]
                                                    : w_rd[k*LANE_W +: LANE_W];
    end

    // Array carries no reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (w_clr_we) begin
            mem[w_clr_addr] <= CLR_VAL;
        end else if (EN && !w_busy) begin
            for (int k = 0; k < NLANE; k++) begin
                if (WE[k]) begin
                    mem[ADDR][k*LANE_W +: LANE_W] <= DI[k*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1 <= INIT;
        end else if (EN && !w_busy) begin
            if (SSR) begin
                r_s1 <= SRVAL;
            end else if (WE == '0) begin
                r_s1 <= w_rd;
            end else if (WRITE_MODE == WM_WRITE_FIRST) begin
                r_s1 <= w_merged;
            end else if (WRITE_MODE == WM_READ_FIRST) begin
                r_s1 <= w_rd;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] r_s2;
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                r_s2 <= INIT;
            end else if (EN && !w_busy) begin
                r_s2 <= SSR ? SRVAL : r_s1;
            end
        end
        assign DO = r_s2;
    end else begin : g_noreg
        assign DO = r_s1;
    end

endmodule

`default_nettype wire
